// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and encodings for the bit-serial adder link
//
// Purpose
//   Holds the host FSM state type and the state encodings of the partner
//   serial adder FSM, so both sides of the link agree on one definition.
//
// Contents
//   host_state_t     : serial_add_host controller states
//   ADD_C*F*         : serial adder state encodings, packed as {carry, f}
//   DEFAULT_WIDTH    : default operand width for the link
//   add_state_pack   : builds an adder state word from carry and sum bit
//
// Build option
//   SERIAL_ADD_OVF_EN (used by serial_add_host) adds the signed overflow flag.

package serial_add_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } host_state_t;

  // The serial adder is a Moore machine whose state is {carry, f}; ser_f and
  // ser_cout are its two state bits brought out directly.
  localparam logic [1:0] ADD_C0F0 = 2'b00;
  localparam logic [1:0] ADD_C0F1 = 2'b01;
  localparam logic [1:0] ADD_C1F0 = 2'b10;
  localparam logic [1:0] ADD_C1F1 = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic [1:0] add_state_pack(input logic carry, input logic f);
    return {carry, f};
  endfunction

endpackage

// File: rtl/ser_piso.sv
// rtl/ser_piso.sv - WIDTH-bit parallel-load, shift-right register with registered LSB output
//
// Purpose
//   Holds one operand and presents it LSB-first on sout, one bit per shift.
//   sout is a flop so the serial line driven off-chip is glitch-free.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset (clears register and sout)
//   load   in   1      capture din; sout forced to 0
//   din    in   WIDTH  parallel operand
//   shift  in   1      move sh[0] to sout and shift the register right
//   clr    in   1      force sout to 0 (end of serial word)
//   sout   out  1      serial output bit

module ser_piso
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             clr,
  output logic             sout
);

  logic [WIDTH-1:0] sh;

  // Priority load > clr > shift; the host never asserts two at once, the
  // ordering only makes the behaviour defined if it ever did.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      sout <= 1'b0;
    end else if (load) begin
      sh   <= din;
      sout <= 1'b0;
    end else if (clr) begin
      sout <= 1'b0;
    end else if (shift) begin
      sout <= sh[0];
      sh   <= {1'b0, sh[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_add_host.sv
// rtl/serial_add_host.sv - initiator side of the bit-serial adder link
//
// Purpose
//   Accepts two parallel operands on start, clears the external serial adder,
//   shifts the operands out LSB-first, collects the Moore sum bits and the
//   final carry, and presents them as a parallel result with a done pulse.
//
// Ports
//   clk        in   1      rising-edge clock, shared with the serial adder
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request, sampled only in IDLE
//   a_in       in   WIDTH  operand A, latched on accepted start
//   b_in       in   WIDTH  operand B, latched on accepted start
//   busy       out  1      1 whenever the controller is not IDLE
//   done       out  1      one-cycle pulse, sum/cout valid
//   sum        out  WIDTH  collected sum, held until the next result
//   cout       out  1      final carry, held like sum
//   ovf        out  1      signed overflow, held like sum (SERIAL_ADD_OVF_EN only)
//   adder_rst  out  1      reset to the serial adder
//   ser_a      out  1      serial bit A
//   ser_b      out  1      serial bit B
//   ser_f      in   1      adder sum bit (reflects the bit driven last cycle)
//   ser_cout   in   1      adder carry state bit
//
// Build option
//   SERIAL_ADD_OVF_EN : adds the ovf output and its operand-sign tracking.
//
// Timing (start sampled at the end of cycle 0)
//   cycle 1 CLR, cycles 2..WIDTH+1 SHIFT, WIDTH+2 DRAIN, WIDTH+3 DONE.

module serial_add_host
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             adder_rst,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_f,
  input  logic             ser_cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  host_state_t      state;
  logic [CW-1:0]    cnt;
  // Bits 0..WIDTH-2 of the sum; bit WIDTH-1 arrives in DRAIN and goes
  // straight into sum, so it never needs a collector flop.
  logic [WIDTH-2:0] col;

  logic piso_load;
  logic piso_shift;
  logic piso_clr;

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // ------------------------------------------------------------------
  // Operand shifters. The edge leaving CLR presents bit 0, each SHIFT edge
  // presents the next bit, and the edge leaving the last SHIFT cycle
  // returns the lines to 0 for DRAIN.
  // ------------------------------------------------------------------
  assign piso_load  = (state == IDLE) && start;
  assign piso_shift = (state == CLR) || ((state == SHIFT) && (cnt != LAST));
  assign piso_clr   = (state == SHIFT) && (cnt == LAST);

  ser_piso #(.WIDTH(WIDTH)) u_piso_a (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .din   (a_in),
    .shift (piso_shift),
    .clr   (piso_clr),
    .sout  (ser_a)
  );

  ser_piso #(.WIDTH(WIDTH)) u_piso_b (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .din   (b_in),
    .shift (piso_shift),
    .clr   (piso_clr),
    .sout  (ser_b)
  );

  // The adder is cleared during CLR so stale carry from a previous word or
  // from idle cycles never leaks into bit 0 of the next result.
  assign adder_rst = rst | (state == CLR);

  // ------------------------------------------------------------------
  // Controller and collector
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      col   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLR;
            busy  <= 1'b1;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            a_msb <= a_in[WIDTH-1];
            b_msb <= b_in[WIDTH-1];
`endif
          end
        end

        CLR: begin
          state <= SHIFT;
        end

        SHIFT: begin
          // ser_f is one cycle behind the bit being driven, so in the
          // cycle driving bit cnt it carries sum bit cnt-1.
          if (cnt != '0) begin
            col[cnt - CW'(1)] <= ser_f;
          end
          if (cnt == LAST) begin
            state <= DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DRAIN: begin
          sum   <= {ser_f, col};
          cout  <= ser_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf   <= (a_msb == b_msb) && (ser_f != a_msb);
`endif
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_host.sv
// tb/tb_serial_add_host.sv - directed self-checking bench for serial_add_host with a serial adder partner

module tb_serial_add_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif
    logic       adder_rst;
    logic       ser_a;
    logic       ser_b;
    logic       ser_f;
    logic       ser_cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_host #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .adder_rst (adder_rst),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_f     (ser_f),
        .ser_cout  (ser_cout)
    );

    always_ff @(posedge clk) begin
        if (adder_rst) begin
            {ser_cout, ser_f} <= 2'b00;
        end else begin
            {ser_cout, ser_f} <= {1'b0, ser_a} + {1'b0, ser_b} + {1'b0, ser_cout};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec);
        int n;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        n = 1;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check("op_latency", n, 11);
        check("op_sum", sum, es);
        check("op_cout", cout, ec);
        tick();
        check("op_done_width", done, 1'b0);
        check("op_busy_after", busy, 1'b0);
        check("op_sum_held", sum, es);
    endtask

    initial begin
        logic [7:0] av;
        logic [7:0] bv;
        int ndone;
        int d0;
        int d1;
        int d2;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_ser_a", ser_a, 1'b0);
        check("rst_ser_b", ser_b, 1'b0);
        check("rst_adder_rst", adder_rst, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        tick();
        check("idle_adder_rst", adder_rst, 1'b0);
        check("idle_busy", busy, 1'b0);

        av = 8'h5A;
        bv = 8'h3C;
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = 8'hC3;
        b_in  = 8'h99;
        for (int c = 1; c <= 10; c++) begin
            check("t1_busy", busy, 1'b1);
            check("t1_done_early", done, 1'b0);
            check("t1_sum_hidden", sum, 8'h00);
            check("t1_adder_rst", adder_rst, (c == 1));
            if (c >= 2 && c <= 9) begin
                check("t1_ser_a", ser_a, av[c-2]);
                check("t1_ser_b", ser_b, bv[c-2]);
            end else begin
                check("t1_ser_a_idle", ser_a, 1'b0);
                check("t1_ser_b_idle", ser_b, 1'b0);
            end
            tick();
        end
        check("t1_done", done, 1'b1);
        check("t1_sum", sum, 8'h96);
        check("t1_cout", cout, 1'b0);
        tick();
        check("t1_done_width", done, 1'b0);
        check("t1_busy_after", busy, 1'b0);

        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0);
        run_op(8'hA5, 8'h5A, 8'hFF, 1'b0);

        a_in  = 8'h11;
        b_in  = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3 || c == 11) begin
                start = 1'b1;
                a_in  = 8'hFF;
                b_in  = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
            if (c == 11) check("t4_done_c11", done, 1'b1);
            if (c == 12) check("t4_busy_c12", busy, 1'b0);
            tick();
        end
        start = 1'b0;
        check("t4_ndone", ndone, 1);
        check("t4_sum", sum, 8'h33);
        check("t4_cout", cout, 1'b0);

        a_in  = 8'h5A;
        b_in  = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t5_busy", busy, 1'b0);
        check("t5_sum", sum, 8'h00);
        check("t5_cout", cout, 1'b0);
        check("t5_adder_rst", adder_rst, 1'b1);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            tick();
        end
        check("t5_no_done", ndone, 0);
        run_op(8'h12, 8'h34, 8'h46, 1'b0);

        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        tick();
        ndone = 0;
        d0 = 0;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 36; c++) begin
            if (done) begin
                if (ndone == 0) d0 = c;
                if (ndone == 1) d1 = c;
                if (ndone == 2) d2 = c;
                ndone++;
            end
            if (c == 36) start = 1'b0;
            tick();
        end
        check("t6_ndone", ndone, 3);
        check("t6_done0", d0, 11);
        check("t6_done1", d1, 23);
        check("t6_done2", d2, 35);
        check("t6_sum", sum, 8'h03);
        check("t6_busy_end", busy, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h7F, 8'h01, 8'h80, 1'b0);
        check("ovf_7f_01", ovf, 1'b1);
        run_op(8'h80, 8'h80, 8'h00, 1'b1);
        check("ovf_80_80", ovf, 1'b1);
        run_op(8'h12, 8'h34, 8'h46, 1'b0);
        check("ovf_12_34", ovf, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
